// File: rtl/cell_scan_ctrl.sv
// cell_scan_ctrl: walks cell origins across a stored frame, one cell per
// accepted handshake. Row base is accumulated (no multiplier); column steps
// by CELL_STEP. Optional linear cell index output when CELL_SCAN_IDX_EN is
// defined (default build omits it).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for iSTART; all outputs zero
// RUN   | presenting cell origins, advancing on each transfer
// DONE  | one-cycle oDONE pulse after the last cell, then back to IDLE

module cell_scan_ctrl #(
  parameter int ROW_SIZE  = 66,
  parameter int CELL_STEP = 8,
  parameter int CELLS_X   = 8,
  parameter int CELLS_Y   = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iABORT,
  input  logic        iREADY,
  output logic        oVALID,
  output logic [13:0] oBEGIN_ROW,
  output logic [6:0]  oBEGIN_COL,
  output logic        oBUSY,
  output logic        oDONE
`ifdef CELL_SCAN_IDX_EN
  ,
  output logic [6:0]  oCELL_IDX
`endif
);

  localparam int XW = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
  localparam int YW = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;
  localparam logic [13:0] ROW_STEP = 14'(CELL_STEP * ROW_SIZE);
  localparam logic [6:0]  COL_STEP = 7'(CELL_STEP);
  localparam logic [XW-1:0] X_LAST = XW'(CELLS_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(CELLS_Y - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0] cell_x;
  logic [YW-1:0] cell_y;
  logic [13:0]   begin_row;
  logic [6:0]    begin_col;

  logic x_last, y_last, xfer, last_xfer, clear;

  assign x_last    = (cell_x == X_LAST);
  assign y_last    = (cell_y == Y_LAST);
  // abort wins over a simultaneous handshake
  assign xfer      = (state == RUN) && iREADY && !iABORT;
  assign last_xfer = xfer && x_last && y_last;
  // counters sit at zero everywhere except while scanning
  assign clear     = (state != RUN) || iABORT || last_xfer;

  // state register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (iSTART && !iABORT) state_nxt = RUN;
      RUN: begin
        if (iABORT)         state_nxt = IDLE;
        else if (last_xfer) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cell position counters and origin accumulators
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cell_x    <= '0;
      cell_y    <= '0;
      begin_row <= '0;
      begin_col <= '0;
    end else if (clear) begin
      cell_x    <= '0;
      cell_y    <= '0;
      begin_row <= '0;
      begin_col <= '0;
    end else if (xfer) begin
      if (x_last) begin
        cell_x    <= '0;
        begin_col <= '0;
        cell_y    <= cell_y + 1'b1;
        begin_row <= begin_row + ROW_STEP;
      end else begin
        cell_x    <= cell_x + 1'b1;
        begin_col <= begin_col + COL_STEP;
      end
    end
  end

`ifdef CELL_SCAN_IDX_EN
  logic [6:0] cell_idx;

  // linear cell index, follows the same clear/advance rules as the origin
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)       cell_idx <= '0;
    else if (clear) cell_idx <= '0;
    else if (xfer)  cell_idx <= cell_idx + 1'b1;
  end

  assign oCELL_IDX = cell_idx;
`endif

  assign oVALID     = (state == RUN);
  assign oBUSY      = (state == RUN);
  assign oDONE      = (state == DONE);
  assign oBEGIN_ROW = begin_row;
  assign oBEGIN_COL = begin_col;

endmodule

// File: doc/cell_scan_ctrl.md
CELL_SCAN_CTRL -- requirements
Module: cell_scan_ctrl

Interface
REQ-001 SHALL have parameter ROW_SIZE, default 66, meaning pixels per stored frame row (64 image + 2 border).
REQ-002 SHALL have parameter CELL_STEP, default 8, meaning pixel stride between adjacent cell origins.
REQ-003 SHALL have parameter CELLS_X, default 8, meaning cells per cell-row.
REQ-004 SHALL have parameter CELLS_Y, default 16, meaning cell-rows per frame.
REQ-005 SHALL have port iCLK  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port iSTART  input  1  frame-scan request, sampled in IDLE only.
REQ-008 SHALL have port iABORT  input  1  synchronous scan cancel.
REQ-009 SHALL have port iREADY  input  1  downstream address decoder/histogram stage accepts current cell.
REQ-010 SHALL have port oVALID  output  1  oBEGIN_ROW/oBEGIN_COL hold a valid cell origin.
REQ-011 SHALL have port oBEGIN_ROW  output  14  linear row base of cell origin (cell_y*CELL_STEP*ROW_SIZE).
REQ-012 SHALL have port oBEGIN_COL  output  7  column of cell origin (cell_x*CELL_STEP).
REQ-013 SHALL have port oBUSY  output  1  high in RUN.
REQ-014 SHALL have port oDONE  output  1  one-cycle pulse after last cell accepted.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-016 SHALL transition IDLE->RUN on iSTART=1 with iABORT=0; cell_x=cell_y=0, oBEGIN_ROW=0, oBEGIN_COL=0, oVALID=1 in the next cycle.
REQ-017 SHALL treat a transfer as oVALID=1 and iREADY=1 on the same rising edge; outputs hold stable while oVALID=1 and iREADY=0.
REQ-018 SHALL on transfer with cell_x<CELLS_X-1 increment cell_x and add CELL_STEP to oBEGIN_COL; oBEGIN_ROW unchanged.
REQ-019 SHALL on transfer with cell_x=CELLS_X-1 and cell_y<CELLS_Y-1 clear cell_x, oBEGIN_COL=0, increment cell_y, add CELL_STEP*ROW_SIZE (528) to oBEGIN_ROW by accumulation, no multiplier.
REQ-020 SHALL on transfer of last cell (cell_x=CELLS_X-1, cell_y=CELLS_Y-1) go to DONE, oVALID=0 next cycle.
REQ-021 SHALL, in DONE, assert oDONE for exactly one cycle then return to IDLE.
REQ-022 SHALL deliver back-to-back transfers at one cell per cycle when iREADY is held high; full frame = CELLS_X*CELLS_Y (128) transfers, oDONE on cycle 129 after first transfer edge.
REQ-023 SHALL ignore iSTART in RUN and DONE.
REQ-024 SHALL on iABORT=1 in RUN or DONE go to IDLE next cycle, clear oVALID, counters and addresses, without oDONE; iABORT takes priority over a simultaneous transfer and over iSTART.
REQ-025 SHALL hold oBEGIN_ROW=0, oBEGIN_COL=0, oVALID=0, oBUSY=0 in IDLE.
REQ-026 SHALL keep max oBEGIN_ROW = (CELLS_Y-1)*528 = 7920 and max oBEGIN_COL = 56 for defaults, within 14/7 bits with no wrap.

Reset
REQ-027 SHALL on iRST=1 immediately force IDLE, oVALID=0, oBUSY=0, oDONE=0, oBEGIN_ROW=0, oBEGIN_COL=0, cell_x=cell_y=0, including mid-scan.
REQ-028 SHALL require a new iSTART after reset release before any oVALID.

Configuration
REQ-029 SHALL, when macro CELL_SCAN_IDX_EN is defined, add output oCELL_IDX (7 bits) = cell_y*CELLS_X+cell_x, reset 0, valid with oVALID, cleared in IDLE.
REQ-030 SHALL, without CELL_SCAN_IDX_EN, omit oCELL_IDX and its counter; all other behaviour identical.

Verification
REQ-031 SHALL cover: iSTART pulse, iREADY held 1 -> 128 transfers, origins (0,0),(0,8)..(0,56),(528,0)..(7920,56), oDONE one cycle after last.
REQ-032 SHALL cover: iREADY low 5 cycles at cell (528,16) -> outputs stable, no skip, next cell (528,24).
REQ-033 SHALL cover: iABORT with iREADY=1 at cell (1056,40) -> oVALID=0 next cycle, no oDONE, IDLE; new iSTART restarts at (0,0).
REQ-034 SHALL cover: iRST asserted mid-scan between clock edges -> outputs zero immediately, oBUSY=0.
REQ-035 SHALL cover: iSTART pulsed during RUN -> ignored, scan count remains 128.
REQ-036 SHALL cover: with CELL_SCAN_IDX_EN, oCELL_IDX = 0..127 matching origins; last cell oCELL_IDX=127 at (7920,56).
